// File: rtl/uart_receiver_pkg.sv
// ---------------------------------------------------------------------------
// uart_receiver_pkg
//   Shared definitions for the 8N1 UART receiver:
//   - default clock / line rate
//   - frame shape constants (data bits, stop bits)
//   - receive FSM state encoding
//   - helper to derive the clock cycles per bit
// ---------------------------------------------------------------------------
package uart_receiver_pkg;

  localparam int DEFAULT_CLOCK_FREQ = 125_000_000;
  localparam int DEFAULT_BAUD_RATE  = 115_200;

  // 8N1 frame: one start bit, eight data bits LSB first, one stop bit.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Whole clock cycles per bit; integer division on purpose.
  function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_receiver_sync.sv
// ---------------------------------------------------------------------------
// uart_receiver_sync
//   Two-flop synchronizer for asynchronous inputs. Both stages reset to
//   RESET_VAL so an idle-high line does not look like a start bit while
//   the receiver comes out of reset.
// Ports
//   clk_i  in          destination clock
//   rst_i  in          asynchronous active-high reset
//   d_i    in  WIDTH   asynchronous input
//   q_o    out WIDTH   synchronized output (two cycles of latency)
// ---------------------------------------------------------------------------
module uart_receiver_sync #(
  parameter int WIDTH     = 1,
  parameter bit RESET_VAL = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= {WIDTH{RESET_VAL}};
      sync_q <= {WIDTH{RESET_VAL}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 serial-to-parallel UART receiver. Incoming bytes are presented on
//   data_out with a valid/ready handshake; framing errors and overruns are
//   reported as single-cycle pulses.
//
//   Handshake: data_out_valid is a registered output and never depends on
//   data_out_ready combinationally. A byte is consumed at any rising clk
//   edge where data_out_valid and data_out_ready are both 1; valid drops in
//   the following cycle. data_out holds steady while valid is 1, except
//   when a newer byte overwrites an unconsumed one (overrun).
//
//   The receive FSM state is held in state_q (rx_state_e) for observation.
// Ports
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   serial_in       in   raw RX line, idle high, asynchronous to clk
//   data_out        out  [7:0] received byte, bit 0 = first data bit
//   data_out_valid  out  data_out holds an unconsumed byte
//   data_out_ready  in   consumer accepts the byte at a valid&ready edge
//   frame_error     out  1-cycle pulse: stop bit sampled as 0
//   overrun         out  1-cycle pulse: unconsumed byte was overwritten
// ---------------------------------------------------------------------------
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int SYMBOL_EDGE_TIME = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam int BIT_W            = $clog2(DATA_BITS);

  // Counters run 0..N-1 and the sample is taken on the last count.
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q,     state_d;
  logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] data_q,      data_d;
  logic                 valid_q,     valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;

  uart_receiver_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (serial_in),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer takes the byte; a byte completing on the same edge below
    // overrides this and keeps valid asserted.
    if (valid_q && data_out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cycle_cnt_d = '0;
        bit_cnt_d   = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cycle_cnt_q == SAMPLE_LAST) begin
          cycle_cnt_d = '0;
          // Line back high at the start-bit centre: treat as a glitch.
          state_d     = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cycle_cnt_q == SYMBOL_LAST) begin
          cycle_cnt_d = '0;
          // LSB arrives first, so shift in from the top.
          shift_d     = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cycle_cnt_q == SYMBOL_LAST) begin
          cycle_cnt_d = '0;
          // Returning to IDLE half a bit early lets a back-to-back start
          // bit be detected on its falling edge.
          state_d     = ST_IDLE;
          if (rx_s) begin
            data_d    = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !data_out_ready;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cycle_cnt_d = '0;
        bit_cnt_d   = '0;
      end
    endcase
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign frame_error    = frame_err_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Directed bench for uart_receiver at 10 clock cycles per bit.
// ---------------------------------------------------------------------------
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam int BIT_CYC = 10;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       data_out_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       frame_error;
  logic       overrun;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_error    (frame_error),
    .overrun        (overrun)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         hs_cnt = 0;   // handshakes seen
  int         vh_cnt = 0;   // cycles with valid high
  int         fe_cnt = 0;   // cycles with frame_error high
  int         ov_cnt = 0;   // cycles with overrun high

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs sampled on the falling edge, half a cycle from the active edge.
  always @(negedge clk) begin
    if (frame_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (data_out_valid === 1'b1) vh_cnt++;
    if (data_out_valid === 1'b1 && data_out_ready === 1'b1) begin
      hs_cnt++;
      check("sb_queue_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("sb_byte", {24'd0, data_out}, {24'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All line drivers assume they start on a falling edge and end on one.
  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 data_out_ready = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0, h0, f0, o0;

    rst            = 1'b1;
    serial_in      = 1'b1;
    data_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_data_out", {24'd0, data_out}, 32'h0);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    rst = 1'b0;
    idle(5);

    // Good frame 0xA5
    v0 = vh_cnt; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_drained", 32'(exp_q.size()), 32'd0);
    check("a5_valid_cycles", 32'(vh_cnt - v0), 32'd1);
    check("a5_frame_error", 32'(fe_cnt - f0), 32'd0);
    check("a5_overrun", 32'(ov_cnt - o0), 32'd0);

    // 3-cycle low glitch
    v0 = vh_cnt; f0 = fe_cnt; o0 = ov_cnt;
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(20);
    check("glitch_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("glitch_valid_cycles", 32'(vh_cnt - v0), 32'd0);
    check("glitch_frame_error", 32'(fe_cnt - f0), 32'd0);
    check("glitch_overrun", 32'(ov_cnt - o0), 32'd0);

    // Frame 0x5A with a bad stop bit
    v0 = vh_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h5A, 1'b0);
    idle(30);
    check("ferr_pulse_cycles", 32'(fe_cnt - f0), 32'd1);
    check("ferr_valid_cycles", 32'(vh_cnt - v0), 32'd0);
    check("ferr_overrun", 32'(ov_cnt - o0), 32'd0);
    check("ferr_data_kept", {24'd0, data_out}, 32'hA5);

    // Overrun: 0x11 left unconsumed, then overwritten by 0x22
    set_ready(1'b0);
    h0 = hs_cnt; o0 = ov_cnt;
    idle(2);
    send_frame(8'h11, 1'b1);
    idle(10);
    check("ovr_first_valid", {31'd0, data_out_valid}, 32'd1);
    check("ovr_first_data", {24'd0, data_out}, 32'h11);
    check("ovr_first_no_flag", 32'(ov_cnt - o0), 32'd0);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    idle(10);
    check("ovr_second_data", {24'd0, data_out}, 32'h22);
    check("ovr_second_valid", {31'd0, data_out_valid}, 32'd1);
    check("ovr_pulse_cycles", 32'(ov_cnt - o0), 32'd1);
    check("ovr_no_handshake", 32'(hs_cnt - h0), 32'd0);
    set_ready(1'b1);
    @(posedge clk);
    #1;
    check("ovr_valid_cleared", {31'd0, data_out_valid}, 32'd0);
    check("ovr_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    idle(5);

    // Reset after four data bits of 0xFF
    serial_in = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    serial_in = 1'b1;
    repeat (4 * BIT_CYC) @(negedge clk);
    check("midrst_in_data", 32'(dut.state_q), 32'(ST_DATA));
    #2 rst = 1'b1;
    #1;
    check("midrst_data_out", {24'd0, data_out}, 32'h0);
    check("midrst_valid", {31'd0, data_out_valid}, 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    v0 = vh_cnt; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check("post_rst_data", {24'd0, data_out}, 32'h3C);
    check("post_rst_valid_cycles", 32'(vh_cnt - v0), 32'd1);
    check("post_rst_flags", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

    // Back-to-back frames, no idle gap
    h0 = hs_cnt; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_handshakes", 32'(hs_cnt - h0), 32'd3);
    check("b2b_frame_error", 32'(fe_cnt - f0), 32'd0);
    check("b2b_overrun", 32'(ov_cnt - o0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
